// File: rtl/lane_deskew_ctrl_pkg.sv
// Shared PHY definitions for the two-lane receive deskew path:
// default word width, default alignment marker and controller state encoding.
package lane_deskew_ctrl_pkg;

   localparam int          DATA_W_DEF     = 32;
   localparam logic [31:0] ALIGN_WORD_DEF = 32'hBCBC_BCBC;

   localparam logic [1:0] ST_HUNT       = 2'd0;
   localparam logic [1:0] ST_WAIT_OTHER = 2'd1;
   localparam logic [1:0] ST_ALIGNED    = 2'd2;

endpackage

// File: rtl/lane_deskew_ctrl_lane_fifo.sv
// Per-lane synchronous FIFO with flush, registered occupancy count and
// first-word-fall-through head data. Flush wins over push/pop.
module lane_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                       clk_2f,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [DATA_W-1:0]          i_din,
   output logic [DATA_W-1:0]          o_dout,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_full;
   logic              w_wr;
   logic              w_rd;

   assign w_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign w_wr = i_push && (!w_full || i_pop);
   assign w_rd = i_pop && !o_empty;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_2f) begin
      if (w_wr && !i_flush) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_2f) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/lane_deskew_ctrl.sv
// Two-lane receive deskew controller: hunts for the alignment marker on both
// lanes, measures the inter-lane skew, buffers post-marker words per lane and
// emits one de-striped stream by popping lane 0 and lane 1 alternately.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// HUNT        | discard words until a marker is seen on either lane
// WAIT_OTHER  | leading lane buffered, counting cycles until lagging marker
// ALIGNED     | both lanes buffered, alternate-lane output stream active
module lane_deskew_ctrl
   import lane_deskew_ctrl_pkg::*;
#(
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                FIFO_DEPTH = 8,
   parameter logic [DATA_W-1:0] ALIGN_WORD = DATA_W'(ALIGN_WORD_DEF)
) (
   input  logic                          clk_2f,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             lane_0,
   input  logic [DATA_W-1:0]             lane_1,
   input  logic                          valid_0,
   input  logic                          valid_1,
   output logic [DATA_W-1:0]             data_out,
   output logic                          valid_out,
   output logic                          aligned,
   output logic [$clog2(FIFO_DEPTH)-1:0] skew,
   output logic                          deskew_err
);

   localparam int SKW_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = SKW_W + 1;

   logic [1:0]        r_state;
   logic              r_lead;
   logic [SKW_W-1:0]  r_cnt;
   logic              r_phase;
   logic [DATA_W-1:0] r_data_out;
   logic              r_valid_out;
   logic              r_aligned;
   logic [SKW_W-1:0]  r_skew;
   logic              r_err;

   logic              w_mk0, w_mk1, w_dat0, w_dat1;
   logic              w_push0_raw, w_push1_raw;
   logic              w_pop0_raw, w_pop1_raw;
   logic              w_push0, w_push1, w_pop0, w_pop1;
   logic              w_ovf0, w_ovf1, w_timeout, w_err;
   logic              w_lag_mk;
   logic [DATA_W-1:0] w_head0, w_head1;
   logic [CNT_W-1:0]  w_cnt0, w_cnt1;
   logic              w_empty0, w_empty1;

   assign w_mk0  = valid_0 && (lane_0 == ALIGN_WORD);
   assign w_mk1  = valid_1 && (lane_1 == ALIGN_WORD);
   assign w_dat0 = valid_0 && !w_mk0;
   assign w_dat1 = valid_1 && !w_mk1;

   assign w_lag_mk = r_lead ? w_mk0 : w_mk1;

   // Which lane words are buffered depends on how far alignment has progressed.
   always_comb begin
      w_push0_raw = 1'b0;
      w_push1_raw = 1'b0;
      case (r_state)
         ST_WAIT_OTHER: begin
            w_push0_raw = w_dat0 && !r_lead;
            w_push1_raw = w_dat1 &&  r_lead;
         end
         ST_ALIGNED: begin
            w_push0_raw = w_dat0;
            w_push1_raw = w_dat1;
         end
         default: ;
      endcase
   end

   // Only the lane selected by phase may pop; the other lane is never skipped ahead.
   assign w_pop0_raw = (r_state == ST_ALIGNED) && !r_phase && !w_empty0;
   assign w_pop1_raw = (r_state == ST_ALIGNED) &&  r_phase && !w_empty1;

   // Overflow is judged on the occupancy left after this cycle's pop.
   assign w_ovf0 = w_push0_raw && ((w_cnt0 - CNT_W'(w_pop0_raw)) == CNT_W'(FIFO_DEPTH));
   assign w_ovf1 = w_push1_raw && ((w_cnt1 - CNT_W'(w_pop1_raw)) == CNT_W'(FIFO_DEPTH));

   // Skew beyond what a FIFO can absorb; a lagging marker on this cycle is too late.
   assign w_timeout = (r_state == ST_WAIT_OTHER) && (r_cnt == SKW_W'(FIFO_DEPTH - 1));

   assign w_err = w_ovf0 || w_ovf1 || w_timeout;

   assign w_push0 = w_push0_raw && !w_err;
   assign w_push1 = w_push1_raw && !w_err;
   assign w_pop0  = w_pop0_raw  && !w_err;
   assign w_pop1  = w_pop1_raw  && !w_err;

   lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
      .clk_2f  (clk_2f),
      .reset   (reset),
      .i_push  (w_push0),
      .i_pop   (w_pop0),
      .i_flush (w_err),
      .i_din   (lane_0),
      .o_dout  (w_head0),
      .o_count (w_cnt0),
      .o_empty (w_empty0)
   );

   lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
      .clk_2f  (clk_2f),
      .reset   (reset),
      .i_push  (w_push1),
      .i_pop   (w_pop1),
      .i_flush (w_err),
      .i_din   (lane_1),
      .o_dout  (w_head1),
      .o_count (w_cnt1),
      .o_empty (w_empty1)
   );

   // Alignment FSM, skew counter, phase and registered output stage.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         r_state     <= ST_HUNT;
         r_lead      <= 1'b0;
         r_cnt       <= '0;
         r_phase     <= 1'b0;
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
         r_aligned   <= 1'b0;
         r_skew      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err       <= w_err;
         r_valid_out <= 1'b0;
         if (w_err) begin
            r_state   <= ST_HUNT;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_aligned <= 1'b0;
            r_skew    <= '0;
         end else begin
            case (r_state)
               ST_HUNT: begin
                  if (w_mk0 && w_mk1) begin
                     r_state   <= ST_ALIGNED;
                     r_skew    <= '0;
                     r_phase   <= 1'b0;
                     r_aligned <= 1'b1;
                  end else if (w_mk0 || w_mk1) begin
                     r_state <= ST_WAIT_OTHER;
                     r_lead  <= w_mk1;
                     r_cnt   <= '0;
                  end
               end
               ST_WAIT_OTHER: begin
                  r_cnt <= r_cnt + SKW_W'(1);
                  if (w_lag_mk) begin
                     r_state   <= ST_ALIGNED;
                     r_skew    <= r_cnt + SKW_W'(1);
                     r_phase   <= 1'b0;
                     r_aligned <= 1'b1;
                  end
               end
               ST_ALIGNED: begin
                  if (w_pop0 || w_pop1) begin
                     r_data_out  <= r_phase ? w_head1 : w_head0;
                     r_valid_out <= 1'b1;
                     r_phase     <= ~r_phase;
                  end
               end
               default: begin
                  r_state <= ST_HUNT;
               end
            endcase
         end
      end
   end

   assign data_out   = r_data_out;
   assign valid_out  = r_valid_out;
   assign aligned    = r_aligned;
   assign skew       = r_skew;
   assign deskew_err = r_err;

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Bench for lane_deskew_ctrl: table-driven cycle vectors with expected
// aligned/deskew_err/skew per row, plus an output-word scoreboard queue.
module tb_lane_deskew_ctrl;

   localparam logic [31:0] MK = 32'hBCBC_BCBC;

   logic        clk_2f = 1'b0;
   logic        reset;
   logic [31:0] lane_0, lane_1;
   logic        valid_0, valid_1;
   logic [31:0] data_out;
   logic        valid_out, aligned, deskew_err;
   logic [2:0]  skew;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic [31:0] l0;
      logic        v0;
      logic [31:0] l1;
      logic        v1;
      logic        ea;
      logic        ee;
      logic [2:0]  es;
      int          n;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t tbl[$];

   always #5 clk_2f = ~clk_2f;

   lane_deskew_ctrl dut (
      .clk_2f     (clk_2f),
      .reset      (reset),
      .lane_0     (lane_0),
      .lane_1     (lane_1),
      .valid_0    (valid_0),
      .valid_1    (valid_1),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .aligned    (aligned),
      .skew       (skew),
      .deskew_err (deskew_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Output scoreboard: every valid word must match the next expected word.
   always @(negedge clk_2f) begin
      if (valid_out === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got=%h want=none", data_out);
         end else begin
            chk("data_out", data_out, sb_q.pop_front());
         end
      end
   end

   task automatic step(input logic [31:0] l0, input logic v0, input logic [31:0] l1, input logic v1);
      lane_0  = l0;
      valid_0 = v0;
      lane_1  = l1;
      valid_1 = v1;
      @(posedge clk_2f);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(32'h0, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic [31:0] l0, input logic v0, input logic [31:0] l1,
                               input logic v1, input logic ea, input logic ee, input logic [2:0] es,
                               input int n, input logic [31:0] w0, input logic [31:0] w1);
      vec_t v;
      v.l0 = l0; v.v0 = v0; v.l1 = l1; v.v1 = v1;
      v.ea = ea; v.ee = ee; v.es = es;
      v.n  = n;  v.w0 = w0; v.w1 = w1;
      return v;
   endfunction

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) begin
         if (tbl[i].n > 0) sb_q.push_back(tbl[i].w0);
         if (tbl[i].n > 1) sb_q.push_back(tbl[i].w1);
         step(tbl[i].l0, tbl[i].v0, tbl[i].l1, tbl[i].v1);
         chk({tag, "_aligned"}, 32'(aligned), 32'(tbl[i].ea));
         chk({tag, "_err"}, 32'(deskew_err), 32'(tbl[i].ee));
         chk({tag, "_skew"}, 32'(skew), 32'(tbl[i].es));
      end
      tbl.delete();
      chk({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int err_at;
      int pulses;
      reset   = 1'b1;
      lane_0  = '0;
      lane_1  = '0;
      valid_0 = 1'b0;
      valid_1 = 1'b0;
      repeat (2) @(posedge clk_2f);
      #1;
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_aligned", 32'(aligned), 32'd0);
      chk("rst_skew", 32'(skew), 32'd0);
      chk("rst_err", 32'(deskew_err), 32'd0);
      reset = 1'b0;

      // Pre-marker garbage followed by zero-skew alignment.
      tbl.push_back(mk(32'h1111_1111, 1, 32'h1111_1111, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'h2222_2222, 1, 32'h2222_2222, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(MK,            1, MK,            1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'hFFFF_FFFF, 1, 32'hEEEE_EEEE, 1, 1, 0, 0, 2, 32'hFFFF_FFFF, 32'hEEEE_EEEE));
      tbl.push_back(mk(32'hDDDD_DDDD, 1, 32'hCCCC_CCCC, 1, 1, 0, 0, 2, 32'hDDDD_DDDD, 32'hCCCC_CCCC));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run_tbl("zero");

      // Lane 1 marker three cycles after lane 0.
      do_reset();
      tbl.push_back(mk(MK,            1, 0,             0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'hFFFF_FFFF, 1, 0,             0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0));
      tbl.push_back(mk(32'hDDDD_DDDD, 1, 0,             0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,             0, MK,            1, 1, 0, 3, 0, 0, 0));
      tbl.push_back(mk(0,             0, 32'hEEEE_EEEE, 1, 1, 0, 3, 2, 32'hEEEE_EEEE, 32'hDDDD_DDDD));
      tbl.push_back(mk(0,             0, 32'hCCCC_CCCC, 1, 1, 0, 3, 1, 32'hCCCC_CCCC, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 0));
      run_tbl("skew3");

      // Skew too large, then a clean realignment; flushed words must not resurface.
      do_reset();
      tbl.push_back(mk(MK,            1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'h9999_9999, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'h9999_9998, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h3333_3333, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(MK, 1, MK, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(32'hAAAA_0001, 1, 32'hAAAA_0002, 1, 1, 0, 0, 2, 32'hAAAA_0001, 32'hAAAA_0002));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run_tbl("toolarge");

      // Overflow: lane 1 goes quiet while lane 0 streams.
      do_reset();
      step(MK, 1'b1, MK, 1'b1);
      chk("ovf_aligned_up", 32'(aligned), 32'd1);
      err_at = -1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 0) sb_q.push_back(32'h5000_0000);
         step(32'h5000_0000 + 32'(i), 1'b1, 32'h0, 1'b0);
         if (deskew_err === 1'b1) begin
            pulses++;
            if (err_at < 0) err_at = i;
         end
      end
      chk("ovf_pulses", 32'(pulses), 32'd1);
      chk("ovf_err_word", 32'(err_at), 32'd9);
      chk("ovf_aligned", 32'(aligned), 32'd0);
      chk("ovf_valid_out", 32'(valid_out), 32'd0);
      step(MK, 1'b1, MK, 1'b1);
      repeat (3) step(32'h0, 1'b0, 32'h0, 1'b0);
      chk("ovf_realign", 32'(aligned), 32'd1);
      chk("ovf_drain", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of the output stream.
      do_reset();
      step(MK, 1'b1, MK, 1'b1);
      sb_q.push_back(32'hA000_0000);
      step(32'hA000_0000, 1'b1, 32'hB000_0000, 1'b1);
      step(32'hA000_0001, 1'b1, 32'hB000_0001, 1'b1);
      reset = 1'b1;
      step(32'hA000_0002, 1'b1, 32'hB000_0002, 1'b1);
      chk("mid_data_out", data_out, 32'h0);
      chk("mid_valid_out", 32'(valid_out), 32'd0);
      chk("mid_aligned", 32'(aligned), 32'd0);
      chk("mid_skew", 32'(skew), 32'd0);
      chk("mid_err", 32'(deskew_err), 32'd0);
      reset = 1'b0;
      repeat (5) step(32'h0, 1'b0, 32'h0, 1'b0);
      chk("mid_aligned_after", 32'(aligned), 32'd0);
      chk("mid_drain", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
